// File: rtl/commit_trace_v_pkg.sv
// ============================================================================
// Module : commit_trace_v_pkg
// Brief  : Shared field widths, packed-entry bit offsets and defaults for the
//          retirement trace FIFO.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package commit_trace_v_pkg;

  localparam int C_DEPTH_DEF    = 8;
  localparam int C_PC_W         = 32;
  localparam int C_INSTR_W      = 32;
  localparam int C_RD_W         = 5;
  localparam int C_DATA_W       = 32;

  // Packed entry layout, LSB first: data, memWrite, regWrite, rd, instr, pc, seq.
  localparam int C_DATA_LSB     = 0;
  localparam int C_MEMW_BIT     = 32;
  localparam int C_REGW_BIT     = 33;
  localparam int C_RD_LSB       = 34;
  localparam int C_INSTR_LSB    = 39;
  localparam int C_PC_LSB       = 71;
  localparam int C_SEQ_LSB      = 103;
  localparam int C_ENTRY_BASE_W = 103;

  // Writes to x0 never change architectural state, so they trace as no-write.
  function automatic logic reg_write_eff(input logic reg_write, input logic [C_RD_W-1:0] rd);
    return reg_write && (rd != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_v_sync_fifo.sv
// ============================================================================
// Module : sync_fifo_v
// Brief  : Single-clock FIFO with registered storage; full-FIFO push is taken
//          only when a pop frees a slot on the same edge.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_fifo_v #(
  parameter int WIDTH = 119,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int C_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [C_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]    count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (C_AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + C_AW'(w_do_push);
    rd_ptr_d = rd_ptr_q + C_AW'(w_do_pop);
    count_d  = count_q;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Stale storage is masked so an empty FIFO presents all-zero fields.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem_q[rd_ptr_q];
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_trace_v.sv
// ============================================================================
// Module : commit_trace_v
// Brief  : Retirement trace buffer: numbers each WB-stage retirement, queues it
//          for a consumer and accounts for entries dropped on overflow.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module commit_trace_v
  import commit_trace_v_pkg::*;
#(
  parameter int DEPTH = C_DEPTH_DEF,
  parameter int SEQ_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_isValid,
  input  logic [C_PC_W-1:0]      wb_pc,
  input  logic [C_INSTR_W-1:0]   wb_instr,
  input  logic [C_RD_W-1:0]      wb_rd,
  input  logic                   wb_regWrite,
  input  logic                   wb_memWrite,
  input  logic [C_DATA_W-1:0]    wb_data,
  input  logic                   trace_ready,
  input  logic                   ovf_clr,
  output logic                   trace_valid,
  output logic [SEQ_W-1:0]       trace_seq,
  output logic [C_PC_W-1:0]      trace_pc,
  output logic [C_INSTR_W-1:0]   trace_instr,
  output logic [C_RD_W-1:0]      trace_rd,
  output logic                   trace_regWrite,
  output logic                   trace_memWrite,
  output logic [C_DATA_W-1:0]    trace_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf_sticky,
  output logic [15:0]            drop_cnt,
  output logic [31:0]            instret
);

  localparam int C_ENTRY_W = SEQ_W + C_ENTRY_BASE_W;

  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [31:0]          instret_q, instret_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [C_ENTRY_W-1:0] w_din;
  logic [C_ENTRY_W-1:0] w_dout;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;

  assign w_din = {seq_q, wb_pc, wb_instr, wb_rd,
                  reg_write_eff(wb_regWrite, wb_rd), wb_memWrite, wb_data};

  sync_fifo_v #(
    .WIDTH (C_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wb_isValid),
    .pop   (trace_ready),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (level)
  );

  // A full FIFO still takes the push when the head leaves on the same edge.
  assign w_drop = wb_isValid && w_full && !(trace_ready && !w_empty);

  always_comb begin
    seq_d      = seq_q;
    instret_d  = instret_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (wb_isValid) begin
      seq_d     = seq_q + SEQ_W'(1);
      instret_d = instret_q + 32'd1;
    end
    if (ovf_clr) begin
      ovf_d      = w_drop;
      drop_cnt_d = {15'd0, w_drop};
    end else if (w_drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q      <= '0;
      instret_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      instret_q  <= instret_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign trace_valid    = !w_empty;
  assign trace_seq      = w_dout[C_SEQ_LSB +: SEQ_W];
  assign trace_pc       = w_dout[C_PC_LSB +: C_PC_W];
  assign trace_instr    = w_dout[C_INSTR_LSB +: C_INSTR_W];
  assign trace_rd       = w_dout[C_RD_LSB +: C_RD_W];
  assign trace_regWrite = w_dout[C_REGW_BIT];
  assign trace_memWrite = w_dout[C_MEMW_BIT];
  assign trace_data     = w_dout[C_DATA_LSB +: C_DATA_W];
  assign ovf_sticky     = ovf_q;
  assign drop_cnt       = drop_cnt_q;
  assign instret        = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_v.sv
// ============================================================================
// Module : tb_commit_trace_v
// Brief  : Directed scoreboard bench for the retirement trace buffer.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_commit_trace_v;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_isValid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic [4:0]  wb_rd;
  logic        wb_regWrite;
  logic        wb_memWrite;
  logic [31:0] wb_data;
  logic        trace_ready;
  logic        ovf_clr;
  logic        trace_valid;
  logic [15:0] trace_seq;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [4:0]  trace_rd;
  logic        trace_regWrite;
  logic        trace_memWrite;
  logic [31:0] trace_data;
  logic [3:0]  level;
  logic        ovf_sticky;
  logic [15:0] drop_cnt;
  logic [31:0] instret;

  commit_trace_v #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_isValid     (wb_isValid),
    .wb_pc          (wb_pc),
    .wb_instr       (wb_instr),
    .wb_rd          (wb_rd),
    .wb_regWrite    (wb_regWrite),
    .wb_memWrite    (wb_memWrite),
    .wb_data        (wb_data),
    .trace_ready    (trace_ready),
    .ovf_clr        (ovf_clr),
    .trace_valid    (trace_valid),
    .trace_seq      (trace_seq),
    .trace_pc       (trace_pc),
    .trace_instr    (trace_instr),
    .trace_rd       (trace_rd),
    .trace_regWrite (trace_regWrite),
    .trace_memWrite (trace_memWrite),
    .trace_data     (trace_data),
    .level          (level),
    .ovf_sticky     (ovf_sticky),
    .drop_cnt       (drop_cnt),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
  } ent_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] seq_m;
  logic [31:0] instret_m;
  logic [15:0] drop_m;
  logic        ovf_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compares every visible output against the model; an empty queue expects zeros.
  task automatic check_state();
    ent_t h;
    h = '{default: '0};
    if (sb.size() > 0) h = sb[0];
    check("valid",    64'(trace_valid),    64'(sb.size() > 0));
    check("level",    64'(level),          64'(sb.size()));
    check("instret",  64'(instret),        64'(instret_m));
    check("drop_cnt", 64'(drop_cnt),       64'(drop_m));
    check("ovf",      64'(ovf_sticky),     64'(ovf_m));
    check("seq",      64'(trace_seq),      64'(h.seq));
    check("pc",       64'(trace_pc),       64'(h.pc));
    check("instr",    64'(trace_instr),    64'(h.instr));
    check("rd",       64'(trace_rd),       64'(h.rd));
    check("regWrite", 64'(trace_regWrite), 64'(h.rw));
    check("memWrite", 64'(trace_memWrite), 64'(h.mw));
    check("data",     64'(trace_data),     64'(h.data));
  endtask

  // One clock: check current outputs, drive inputs for the next edge, advance the model.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] rd, input logic rw, input logic mw,
                       input logic [31:0] data, input logic rdy, input logic clr);
    logic pop;
    logic drop;
    ent_t e;
    check_state();
    wb_isValid  = v;
    wb_pc       = pc;
    wb_instr    = instr;
    wb_rd       = rd;
    wb_regWrite = rw;
    wb_memWrite = mw;
    wb_data     = data;
    trace_ready = rdy;
    ovf_clr     = clr;
    pop  = rdy && (sb.size() > 0);
    drop = v && (sb.size() == DEPTH) && !pop;
    if (pop) void'(sb.pop_front());
    if (v) begin
      if (!drop) begin
        e.seq = seq_m; e.pc = pc; e.instr = instr; e.data = data;
        e.rd = rd; e.rw = rw && (rd != 5'd0); e.mw = mw;
        sb.push_back(e);
      end
      seq_m++;
      instret_m++;
    end
    if (clr) begin
      ovf_m  = drop;
      drop_m = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      ovf_m = 1'b1;
      if (drop_m != 16'hFFFF) drop_m++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, rdy, clr);
  endtask

  task automatic push_rand(input logic [31:0] pc, input logic rdy, input logic clr);
    drive(1'b1, pc, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom, rdy, clr);
  endtask

  initial begin
    reset = 1'b1;
    wb_isValid = 0; wb_pc = 0; wb_instr = 0; wb_rd = 0; wb_regWrite = 0;
    wb_memWrite = 0; wb_data = 0; trace_ready = 0; ovf_clr = 0;
    seq_m = 0; instret_m = 0; drop_m = 0; ovf_m = 0;
    repeat (2) @(negedge clk);
    check_state();
    reset = 1'b0;

    // Three back-to-back retirements drained as they appear.
    drive(1'b1, 32'h0, 32'h00000013, 5'd1, 1'b1, 1'b0, 32'h11, 1'b1, 1'b0);
    check("peak_lvl0", 64'(level), 64'd1);
    drive(1'b1, 32'h4, 32'h00100093, 5'd2, 1'b1, 1'b0, 32'h22, 1'b1, 1'b0);
    check("peak_lvl1", 64'(level), 64'd1);
    drive(1'b1, 32'h8, 32'h00200113, 5'd3, 1'b0, 1'b1, 32'h33, 1'b1, 1'b0);
    check("peak_lvl2", 64'(level), 64'd1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("instret3", 64'(instret), 64'd3);

    // x0 destination is recorded as no-write; non-zero rd keeps it.
    drive(1'b1, 32'h100, 32'h00000033, 5'd0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    drive(1'b1, 32'h104, 32'h00000033, 5'd7, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Overflow with the consumer stalled; head must hold steady.
    for (int i = 0; i < 10; i++) push_rand(32'h200 + 32'(4 * i), 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("ovf_lvl8", 64'(level), 64'd8);
    check("ovf_drop2", 64'(drop_cnt), 64'd2);
    check("ovf_sticky", 64'(ovf_sticky), 64'd1);

    // Full FIFO with simultaneous push and pop, then drain.
    push_rand(32'h300, 1'b1, 1'b0);
    check("full_pp_lvl", 64'(level), 64'd8);
    check("full_pp_drop", 64'(drop_cnt), 64'd2);
    repeat (9) idle(1'b1, 1'b0);

    // Clear, then clear coincident with a drop.
    idle(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push_rand(32'h400 + 32'(4 * i), 1'b0, 1'b0);
    push_rand(32'h500, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd1);

    // Drop counter saturation.
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    drop_m = 16'hFFFE;
    push_rand(32'h600, 1'b0, 1'b0);
    push_rand(32'h604, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("drop_sat", 64'(drop_cnt), 64'hFFFF);
    idle(1'b0, 1'b1);
    repeat (9) idle(1'b1, 1'b0);

    // Sequence number wrap.
    force dut.seq_q = 16'hFFFE;
    #1;
    release dut.seq_q;
    seq_m = 16'hFFFE;
    push_rand(32'h700, 1'b1, 1'b0);
    push_rand(32'h704, 1'b1, 1'b0);
    push_rand(32'h708, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Asynchronous reset mid-cycle with five entries queued.
    for (int i = 0; i < 5; i++) push_rand(32'h800 + 32'(4 * i), 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("pre_rst_lvl", 64'(level), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_seq", 64'(trace_seq), 64'd0);
    sb.delete();
    seq_m = 0; instret_m = 0; drop_m = 0; ovf_m = 0;
    @(negedge clk);
    check_state();
    reset = 1'b0;
    push_rand(32'h900, 1'b1, 1'b0);
    check("post_rst_seq", 64'(trace_seq), 64'd0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
